// File: rtl/regfile_writeback_ctrl_if.sv
// Writeback bundle: ALU/LSU result inputs, register-file and PC-redirect outputs,
// and status exported to the decoder.
interface regfile_writeback_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                     alu_valid;
  logic [ADDR_WIDTH-1:0]    alu_rd;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [ADDR_WIDTH-1:0]    lsu_rd;
  logic [DATA_WIDTH-1:0]    lsu_data;
  logic                     rf_we;
  logic [ADDR_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;
  logic                     pc_wr_en;
  logic [DATA_WIDTH-1:0]    pc_wr_data;
  logic [2**ADDR_WIDTH-1:0] pending_mask;
  logic [CNT_W-1:0]         fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_result, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, rf_we, rf_waddr, rf_wdata, pc_wr_en, pc_wr_data,
           pending_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, rf_we, rf_waddr, rf_wdata, pc_wr_en, pc_wr_data,
           pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback: merges the ALU stream with FIFO-buffered LSU results,
// diverts R15 writes to a PC redirect, and exports a pending-write mask.
module regfile_writeback_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_writeback_ctrl_if.slave wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_REG = '1;

  logic [ADDR_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_rf_we;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic                  r_pc_wr_en;
  logic [DATA_WIDTH-1:0] r_pc_wr_data;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_valid;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NREG-1:0]       w_pend;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Full refuses a push even when a pop happens in the same cycle.
  assign w_push  = wb.lsu_valid && !w_full;
  assign w_pop   = !wb.alu_valid && !w_empty;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    if (wb.alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = wb.alu_rd;
      w_sel_data  = wb.alu_result;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_fifo_rd[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= wb.lsu_rd;
      r_fifo_data[r_wr_ptr] <= wb.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fifo_vld <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_fifo_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr             <= r_rd_ptr + 1'b1;
        r_fifo_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_pc_wr_en   <= 1'b0;
      r_pc_wr_data <= '0;
    end else begin
      r_rf_we    <= 1'b0;
      r_pc_wr_en <= 1'b0;
      if (w_sel_valid) begin
        if (w_sel_rd == PC_REG) begin
          r_pc_wr_en   <= 1'b1;
          r_pc_wr_data <= {w_sel_data[DATA_WIDTH-1:2], 2'b00};
        end else begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= w_sel_rd;
          r_rf_wdata <= w_sel_data;
        end
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (r_fifo_vld[i]) w_pend[r_fifo_rd[i]] = 1'b1;
    end
    if (r_rf_we) w_pend[r_rf_waddr] = 1'b1;
    w_pend[NREG-1] = 1'b0;
  end

  assign wb.lsu_ready    = !w_full;
  assign wb.rf_we        = r_rf_we;
  assign wb.rf_waddr     = r_rf_waddr;
  assign wb.rf_wdata     = r_rf_wdata;
  assign wb.pc_wr_en     = r_pc_wr_en;
  assign wb.pc_wr_data   = r_pc_wr_data;
  assign wb.pending_mask = w_pend;
  assign wb.fifo_count   = r_count;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl: a queue-level reference model predicts
// each commit when stimulus is issued; a negedge monitor compares the outputs.
module tb_regfile_writeback_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_writeback_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  regfile_writeback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] rd; logic [31:0] data; } lsu_t;
  typedef struct { logic pc; logic [3:0] addr; logic [31:0] data; } wr_t;

  lsu_t        m_q[$];
  wr_t         exp_q[$];
  logic [15:0] m_pend = '0;
  logic [3:0]  mon_last_addr = '0;
  logic [31:0] mon_last_data = '0;
  logic [31:0] mon_last_pc   = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input logic [3:0] rd, input logic [31:0] d);
    wr_t w;
    w.pc   = (rd == 4'd15);
    w.addr = rd;
    w.data = w.pc ? (d & 32'hFFFF_FFFC) : d;
    return w;
  endfunction

  // Reference: ALU first, else oldest buffered LSU result; a push needs a non-full
  // buffer as seen before this cycle's pop.
  task automatic model_step();
    wr_t it;
    bit  sel;
    bit  full;
    full = (m_q.size() == DEPTH);
    sel  = 1'b0;
    if (bus.alu_valid) begin
      sel = 1'b1;
      it  = mk(bus.alu_rd, bus.alu_result);
    end else if (m_q.size() != 0) begin
      sel = 1'b1;
      it  = mk(m_q[0].rd, m_q[0].data);
      void'(m_q.pop_front());
    end
    if (bus.lsu_valid && !full) m_q.push_back('{bus.lsu_rd, bus.lsu_data});
    if (sel) exp_q.push_back(it);
    m_pend = '0;
    foreach (m_q[i]) m_pend[m_q[i].rd] = 1'b1;
    if (sel && !it.pc) m_pend[it.addr] = 1'b1;
    m_pend[15] = 1'b0;
  endtask

  task automatic cyc(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [3:0] lrd, input logic [31:0] ld);
    @(negedge clk);
    #1;
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_result = ad;
    bus.lsu_valid  = lv;
    bus.lsu_rd     = lrd;
    bus.lsu_data   = ld;
    if (rst_n) model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic clear_model();
    m_q.delete();
    exp_q.delete();
    m_pend        = '0;
    mon_last_addr = '0;
    mon_last_data = '0;
    mon_last_pc   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_we"},    bus.rf_we,        0);
    check({tag, "_waddr"},    bus.rf_waddr,     0);
    check({tag, "_wdata"},    bus.rf_wdata,     0);
    check({tag, "_pc_en"},    bus.pc_wr_en,     0);
    check({tag, "_pc_data"},  bus.pc_wr_data,   0);
    check({tag, "_pending"},  bus.pending_mask, 0);
    check({tag, "_count"},    bus.fifo_count,   0);
  endtask

  initial begin : monitor
    wr_t it;
    bit  have;
    forever begin
      @(negedge clk);
      have = (exp_q.size() != 0);
      if (have) it = exp_q.pop_front();
      check("rf_we",    bus.rf_we,    have && !it.pc);
      check("pc_wr_en", bus.pc_wr_en, have && it.pc);
      if (have && !it.pc) begin
        check("rf_waddr", bus.rf_waddr, it.addr);
        check("rf_wdata", bus.rf_wdata, it.data);
        mon_last_addr = it.addr;
        mon_last_data = it.data;
      end else begin
        check("rf_waddr_hold", bus.rf_waddr, mon_last_addr);
        check("rf_wdata_hold", bus.rf_wdata, mon_last_data);
      end
      if (have && it.pc) begin
        check("pc_wr_data", bus.pc_wr_data, it.data);
        mon_last_pc = it.data;
      end else begin
        check("pc_wr_data_hold", bus.pc_wr_data, mon_last_pc);
      end
      check("pending_mask", bus.pending_mask, m_pend);
      check("fifo_count",   bus.fifo_count,   m_q.size());
      check("lsu_ready",    bus.lsu_ready,    m_q.size() != DEPTH);
    end
  end

  initial begin : stimulus
    int pa;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_result = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data   = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    check("ready_after_reset", bus.lsu_ready, 1);

    // ALU write, one-cycle latency
    cyc(1'b1, 4'd3, 32'h1111_0003, 1'b0, 4'd0, 32'd0);
    idle(3);

    // Two LSU pushes back to back
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hCAFE_0006);
    idle(4);

    // Fill the buffer behind a stalling ALU stream, then try a fifth push
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 4'd8, 32'hA000_0000 + i, 1'b1, 4'(i), 32'h4000_0000 + i);
    cyc(1'b1, 4'd9, 32'hA000_0005, 1'b1, 4'd9, 32'h4000_0009);
    check("full_count", bus.fifo_count, 4);
    check("full_ready", bus.lsu_ready,  0);
    idle(7);

    // R15 redirects from both producers
    cyc(1'b1, 4'd15, 32'h0000_2007, 1'b0, 4'd0, 32'd0);
    idle(2);
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h0000_300B);
    idle(4);

    // ALU wins over a waiting FIFO head
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h7777_0007);
    cyc(1'b1, 4'd2, 32'h2222_0002, 1'b0, 4'd0, 32'd0);
    idle(4);

    // Asynchronous reset with entries buffered and a write on the outputs
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'd10, 32'hB000_0000 + i, 1'b1, 4'(11 + i), 32'hC000_0000 + i);
    cyc(1'b1, 4'd9, 32'h9999_0009, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    #2;
    check("pre_reset_we", bus.rf_we, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    clear_model();
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // Randomised traffic with varying ALU load to exercise fill and drain
    for (int e = 0; e < 15; e++) begin
      case (e % 3)
        0:       pa = 10;
        1:       pa = 45;
        default: pa = 90;
      endcase
      for (int i = 0; i < 100; i++) begin
        cyc($urandom_range(0, 99) < pa, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom);
      end
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
